// File: rtl/sm3_pad_strm.sv
// SM3 message padder: turns 32/64-bit big-endian input beats into padded 32-bit words
// (0x80 marker, zero fill, 64-bit bit length). Define SM3_PAD_ERR_CHK_EN for a sticky mask-protocol error flag.
module sm3_pad_strm #(
  parameter int INPT_DW     = 32,
  parameter int INPT_BYTE_W = INPT_DW / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPT_DW-1:0]     msg_inpt_d,
  input  logic [INPT_BYTE_W-1:0] msg_inpt_vld_byte,
  input  logic                   msg_inpt_vld,
  output logic                   msg_inpt_rdy,
  input  logic                   msg_inpt_lst,
  output logic [31:0]            pad_otpt_d,
  output logic                   pad_otpt_vld,
  input  logic                   pad_otpt_rdy,
  output logic                   pad_otpt_blk_lst,
  output logic                   pad_otpt_msg_lst,
  output logic                   pad_err
);

  typedef enum logic [1:0] {ST_DATA, ST_PAD, ST_LEN_H, ST_LEN_L} st_e;

  st_e         st_q, st_d;
  logic [3:0]  idx_q, idx_d;
  logic [60:0] cnt_q, cnt_d;
  logic        need80_q, need80_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_w_q, pend_w_d;
  logic [2:0]  pend_nb_q, pend_nb_d;
  logic        pend_lst_q, pend_lst_d;
  logic        o_vld_q, o_vld_d;
  logic [31:0] o_w_q, o_w_d;
  logic        o_blk_q, o_blk_d;
  logic        o_msg_q, o_msg_d;

  logic [31:0] beat_hi, beat_lo;
  logic [3:0]  mask_hi, mask_lo;
  logic        two_words;
  logic        ld_ok, acc, ld, ld_msg;
  logic [31:0] ld_w;
  logic        cur_go, cur_lst;
  logic [31:0] cur_w;
  logic [2:0]  cur_nb;
  logic [63:0] len_bits;

  function automatic logic [2:0] popcnt4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  // Keep the nb leading bytes, place the 0x80 marker in the next byte, zero the rest.
  function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [2:0] nb);
    case (nb)
      3'd1:    return {w[31:24], 8'h80, 16'h0000};
      3'd2:    return {w[31:16], 8'h80, 8'h00};
      3'd3:    return {w[31:8], 8'h80};
      default: return 32'h8000_0000;
    endcase
  endfunction

  if (INPT_DW == 64) begin : g_dw64
    assign beat_hi   = msg_inpt_d[63:32];
    assign beat_lo   = msg_inpt_d[31:0];
    assign mask_hi   = msg_inpt_vld_byte[7:4];
    assign mask_lo   = msg_inpt_vld_byte[3:0];
    assign two_words = 1'b1;
  end else begin : g_dw32
    assign beat_hi   = msg_inpt_d[31:0];
    assign beat_lo   = '0;
    assign mask_hi   = msg_inpt_vld_byte[3:0];
    assign mask_lo   = '0;
    assign two_words = 1'b0;
  end

  assign ld_ok        = !o_vld_q || pad_otpt_rdy;
  assign msg_inpt_rdy = !rst && (st_q == ST_DATA) && !pend_q && ld_ok;
  assign acc          = msg_inpt_vld && msg_inpt_rdy;
  assign len_bits     = {cnt_q, 3'b000};

  always_comb begin
    st_d       = st_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    need80_d   = need80_q;
    pend_d     = pend_q;
    pend_w_d   = pend_w_q;
    pend_nb_d  = pend_nb_q;
    pend_lst_d = pend_lst_q;
    o_vld_d    = o_vld_q;
    o_w_d      = o_w_q;
    o_blk_d    = o_blk_q;
    o_msg_d    = o_msg_q;
    ld         = 1'b0;
    ld_w       = '0;
    ld_msg     = 1'b0;
    cur_go     = acc;
    cur_w      = beat_hi;
    cur_nb     = popcnt4(mask_hi);
    cur_lst    = msg_inpt_lst && (mask_lo == 4'h0);
    if (pend_q) begin
      cur_go  = ld_ok;
      cur_w   = pend_w_q;
      cur_nb  = pend_nb_q;
      cur_lst = pend_lst_q;
    end

    // A 64-bit beat whose low word still carries bytes parks that word for the next slot.
    if (acc) begin
      cnt_d = cnt_q + 61'(popcnt4(mask_hi)) + 61'(popcnt4(mask_lo));
      if (two_words && !cur_lst) begin
        pend_d     = 1'b1;
        pend_w_d   = beat_lo;
        pend_nb_d  = popcnt4(mask_lo);
        pend_lst_d = msg_inpt_lst;
      end
    end

    case (st_q)
      ST_DATA: begin
        if (cur_go) begin
          if (pend_q) pend_d = 1'b0;
          if (!cur_lst) begin
            ld   = 1'b1;
            ld_w = cur_w;
          end else if (cur_nb == 3'd0) begin
            st_d     = ST_PAD;
            need80_d = 1'b1;
          end else if (cur_nb[2]) begin
            ld       = 1'b1;
            ld_w     = cur_w;
            st_d     = ST_PAD;
            need80_d = 1'b1;
          end else begin
            ld       = 1'b1;
            ld_w     = pad_word(cur_w, cur_nb);
            st_d     = (idx_q == 4'd13) ? ST_LEN_H : ST_PAD;
            need80_d = 1'b0;
          end
        end
      end
      ST_PAD: begin
        if (ld_ok) begin
          ld       = 1'b1;
          ld_w     = need80_q ? 32'h8000_0000 : 32'h0;
          need80_d = 1'b0;
          if (idx_q == 4'd13) st_d = ST_LEN_H;
        end
      end
      ST_LEN_H: begin
        if (ld_ok) begin
          ld   = 1'b1;
          ld_w = len_bits[63:32];
          st_d = ST_LEN_L;
        end
      end
      ST_LEN_L: begin
        if (ld_ok) begin
          ld     = 1'b1;
          ld_w   = len_bits[31:0];
          ld_msg = 1'b1;
          st_d   = ST_DATA;
          cnt_d  = '0;
        end
      end
      default: st_d = ST_DATA;
    endcase

    if (ld) begin
      o_vld_d = 1'b1;
      o_w_d   = ld_w;
      o_blk_d = (idx_q == 4'd15);
      o_msg_d = ld_msg;
      idx_d   = idx_q + 4'd1;
    end else if (o_vld_q && pad_otpt_rdy) begin
      o_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= ST_DATA;
      idx_q    <= '0;
      cnt_q    <= '0;
      need80_q <= 1'b0;
      pend_q   <= 1'b0;
      o_vld_q  <= 1'b0;
      o_w_q    <= '0;
      o_blk_q  <= 1'b0;
      o_msg_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      need80_q <= need80_d;
      pend_q   <= pend_d;
      o_vld_q  <= o_vld_d;
      o_w_q    <= o_w_d;
      o_blk_q  <= o_blk_d;
      o_msg_q  <= o_msg_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_w_q   <= pend_w_d;
    pend_nb_q  <= pend_nb_d;
    pend_lst_q <= pend_lst_d;
  end

  assign pad_otpt_d       = o_w_q;
  assign pad_otpt_vld     = o_vld_q;
  assign pad_otpt_blk_lst = o_blk_q;
  assign pad_otpt_msg_lst = o_msg_q;

`ifdef SM3_PAD_ERR_CHK_EN
  // A legal mask inverted is a run of low-order ones, so inv & (inv+1) is zero.
  logic [INPT_BYTE_W-1:0] inv_mask, inv_inc;
  logic                   mask_bad, err_q, err_d;
  assign inv_mask = ~msg_inpt_vld_byte;
  assign inv_inc  = inv_mask + INPT_BYTE_W'(1);
  assign mask_bad = ((inv_mask & inv_inc) != '0) || (!msg_inpt_lst && (msg_inpt_vld_byte != '1));
  assign err_d    = err_q || (acc && mask_bad);
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign pad_err = err_q;
`else
  assign pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_sm3_pad_strm.sv
// Directed bench for sm3_pad_strm: a 32-bit and a 64-bit instance driven from a vector table,
// plus hand sequences for mid-stream reset and the mask error flag.
module tb_sm3_pad_strm;

`ifdef SM3_PAD_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    bit          w64;
    bit          rnd;
    int          nbeats;
    logic [63:0] beat;
    logic [7:0]  lmask;
    int          nwords;
    int          p80;
    logic [31:0] w80;
    logic [31:0] len_l;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_rdy = 1'b1;
  logic        lst = 1'b0;
  logic [31:0] i32_d = '0;
  logic [3:0]  i32_m = '0;
  logic        i32_vld = 1'b0, i32_rdy;
  logic [31:0] o32_d;
  logic        o32_vld, o32_b, o32_m, e32;
  logic [63:0] i64_d = '0;
  logic [7:0]  i64_m = '0;
  logic        i64_vld = 1'b0, i64_rdy;
  logic [31:0] o64_d;
  logic        o64_vld, o64_b, o64_m, e64;

  int          checks = 0;
  int          errors = 0;
  logic [33:0] q[$];
  bit          hv, hr, acc_g;
  logic [33:0] ho;
  vec_t        vecs[13];

  always #5 clk = ~clk;

  sm3_pad_strm #(.INPT_DW(32)) u32 (
    .clk(clk), .rst(rst), .msg_inpt_d(i32_d), .msg_inpt_vld_byte(i32_m),
    .msg_inpt_vld(i32_vld), .msg_inpt_rdy(i32_rdy), .msg_inpt_lst(lst),
    .pad_otpt_d(o32_d), .pad_otpt_vld(o32_vld), .pad_otpt_rdy(o_rdy),
    .pad_otpt_blk_lst(o32_b), .pad_otpt_msg_lst(o32_m), .pad_err(e32)
  );

  sm3_pad_strm #(.INPT_DW(64)) u64 (
    .clk(clk), .rst(rst), .msg_inpt_d(i64_d), .msg_inpt_vld_byte(i64_m),
    .msg_inpt_vld(i64_vld), .msg_inpt_rdy(i64_rdy), .msg_inpt_lst(lst),
    .pad_otpt_d(o64_d), .pad_otpt_vld(o64_vld), .pad_otpt_rdy(o_rdy),
    .pad_otpt_blk_lst(o64_b), .pad_otpt_msg_lst(o64_m), .pad_err(e64)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic sample(input bit w64);
    logic        v;
    logic [33:0] o;
    v = w64 ? o64_vld : o32_vld;
    o = w64 ? {o64_d, o64_b, o64_m} : {o32_d, o32_b, o32_m};
    if (hv && !hr) chk("hold", {29'b0, v, o}, {29'b0, 1'b1, ho});
    if (v && o_rdy) q.push_back(o);
    hv = v;
    hr = o_rdy;
    ho = o;
  endtask

  task automatic drive(input vec_t v, input int b);
    logic [7:0] m;
    i32_vld = 1'b0;
    i64_vld = 1'b0;
    lst     = 1'b0;
    if (b < v.nbeats) begin
      lst = (b == v.nbeats - 1);
      m   = lst ? v.lmask : 8'hff;
      if (v.w64) begin
        i64_vld = 1'b1; i64_d = v.beat; i64_m = m;
      end else begin
        i32_vld = 1'b1; i32_d = v.beat[63:32]; i32_m = m[7:4];
      end
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int          b, cyc;
    bit          acc;
    logic [31:0] ew;
    logic [33:0] e;
    q.delete();
    hv  = 1'b0;
    b   = 0;
    cyc = 0;
    drive(v, b);
    o_rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while ((b < v.nbeats || q.size() < v.nwords) && cyc < 600) begin
      @(negedge clk);
      sample(v.w64);
      acc = v.w64 ? (i64_vld && i64_rdy) : (i32_vld && i32_rdy);
      @(posedge clk); #1;
      if (acc) b++;
      drive(v, b);
      o_rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    o_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample(v.w64);
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d_count", id), 64'(q.size()), 64'(v.nwords));
    for (int k = 0; k < v.nwords && k < q.size(); k++) begin
      if (k < v.p80)                ew = (v.w64 && (k % 2 == 1)) ? v.beat[31:0] : v.beat[63:32];
      else if (k == v.p80)          ew = v.w80;
      else if (k == v.nwords - 1)   ew = v.len_l;
      else                          ew = 32'h0;
      e = {ew, (k % 16 == 15), (k == v.nwords - 1)};
      chk($sformatf("v%0d_word%0d", id, k), {30'b0, q[k]}, {30'b0, e});
    end
  endtask

  initial begin
    //               w64   rnd  beats beat                      lmask  nw  p80 w80            len_l
    vecs[0]  = '{1'b0, 1'b0, 1,  64'h6162_6300_0000_0000, 8'he0, 16, 0,  32'h6162_6380, 32'h18};
    vecs[1]  = '{1'b1, 1'b0, 1,  64'h6162_6300_0000_0000, 8'he0, 16, 0,  32'h6162_6380, 32'h18};
    vecs[2]  = '{1'b1, 1'b0, 8,  64'h6162_6364_6162_6364, 8'hff, 32, 16, 32'h8000_0000, 32'h200};
    vecs[3]  = '{1'b0, 1'b0, 14, 64'h6162_6364_0000_0000, 8'hf0, 32, 14, 32'h8000_0000, 32'h1C0};
    vecs[4]  = '{1'b0, 1'b0, 1,  64'h0,                   8'h00, 16, 0,  32'h8000_0000, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1,  64'h0,                   8'h00, 16, 0,  32'h8000_0000, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1,  64'h1122_3344_5566_7788, 8'hf8, 16, 1,  32'h5580_0000, 32'h28};
    vecs[7]  = '{1'b0, 1'b0, 14, 64'h6162_6364_0000_0000, 8'hc0, 16, 13, 32'h6162_8000, 32'h1B0};
    vecs[8]  = '{1'b0, 1'b0, 15, 64'h6162_6364_0000_0000, 8'hf0, 32, 15, 32'h8000_0000, 32'h1E0};
    vecs[9]  = '{1'b0, 1'b0, 15, 64'h6162_6364_0000_0000, 8'h80, 32, 14, 32'h6180_0000, 32'h1C8};
    vecs[10] = '{1'b1, 1'b0, 7,  64'h6162_6364_6162_6364, 8'hf0, 16, 13, 32'h8000_0000, 32'h1A0};
    vecs[11] = '{1'b0, 1'b1, 1,  64'h6162_6300_0000_0000, 8'he0, 16, 0,  32'h6162_6380, 32'h18};
    vecs[12] = '{1'b1, 1'b1, 8,  64'h6162_6364_6162_6364, 8'hff, 32, 16, 32'h8000_0000, 32'h200};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out32", {o32_vld, o32_b, o32_m, i32_rdy, e32, o32_d}, '0);
    chk("rst_out64", {o64_vld, o64_b, o64_m, i64_rdy, e64, o64_d}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {i32_rdy, i64_rdy}, 2'b11);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a message, then a clean rerun of the short message.
    o_rdy   = 1'b1;
    i32_vld = 1'b1; i32_d = 32'hdead_beef; i32_m = 4'hf; lst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_out", {o32_vld, o32_b, o32_m, i32_rdy, o32_d}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    i32_vld = 1'b0;
    @(negedge clk);
    chk("mid_rst_rdy", {i32_rdy, o32_vld}, 2'b10);
    @(posedge clk); #1;
    run_vec(99, vecs[0]);

    // Non-contiguous mask on a last beat.
    i32_d = 32'ha5a5_a5a5; i32_m = 4'b1010; lst = 1'b1; i32_vld = 1'b1; o_rdy = 1'b1;
    acc_g = 1'b0;
    for (int c = 0; c < 50 && !acc_g; c++) begin
      @(negedge clk);
      acc_g = i32_rdy;
      @(posedge clk); #1;
    end
    i32_vld = 1'b0; lst = 1'b0;
    chk("err_accept", {63'b0, acc_g}, 64'd1);
    @(negedge clk);
    chk("err_set", {63'b0, e32}, {63'b0, ERR_EN});
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", {63'b0, e32}, {63'b0, ERR_EN});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_clear", {e32, e64}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
